// File: rtl/bch_pkg.sv
// Shared definitions for the BCH(31,k,T=3) decoder over GF(2^5), primitive polynomial x^5+x^2+1.
package bch_pkg;

  localparam int unsigned N = 31;
  localparam int unsigned M = 5;
  localparam int unsigned T = 3;

  typedef logic [M-1:0] gf_t;

  // Low bits of the primitive polynomial; x^5 folds back to x^2+1.
  localparam gf_t PRIM_LOW = 5'b00101;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FIN
  } chien_state_t;

  // alpha^k for k = 0..30
  localparam gf_t ALPHA_TBL [0:30] = '{
    5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd5,  5'd10, 5'd20,
    5'd13, 5'd26, 5'd17, 5'd7,  5'd14, 5'd28, 5'd29, 5'd31,
    5'd27, 5'd19, 5'd3,  5'd6,  5'd12, 5'd24, 5'd21, 5'd15,
    5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,  5'd18
  };

  function automatic gf_t alpha_pow(input int unsigned k);
    return ALPHA_TBL[k % N];
  endfunction

  // General shift-and-add multiply.
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t acc;
    gf_t sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_LOW : gf_t'(0));
    end
    return acc;
  endfunction

  // a^-1 = a^(2^M - 2); maps 0 to 0.
  function automatic gf_t gf_inv(input gf_t a);
    gf_t r;
    r = gf_t'(1);
    for (int unsigned i = 0; i < (1 << M) - 2; i++) begin
      r = gf_mul(r, a);
    end
    return r;
  endfunction

endpackage

// File: rtl/bch_chien_search_if.sv
// Handshake and data bundle between the Berlekamp-Massey stage (master) and the Chien search (slave).
interface bch_chien_search_if;
  import bch_pkg::*;

  logic       start;
  gf_t        sigma0;
  gf_t        sigma1;
  gf_t        sigma2;
  gf_t        sigma3;
  logic [3:0] L;
  logic       busy;
  logic       pos_valid;
  logic [4:0] err_pos;
  logic       err_flag;
  logic       done;
  logic [3:0] num_err;
  logic       fail;

  modport master (
    output start, sigma0, sigma1, sigma2, sigma3, L,
    input  busy, pos_valid, err_pos, err_flag, done, num_err, fail
  );

  modport slave (
    input  start, sigma0, sigma1, sigma2, sigma3, L,
    output busy, pos_valid, err_pos, err_flag, done, num_err, fail
  );

endinterface

// File: rtl/gf5_mul_const.sv
// Combinational multiply of a GF(2^5) element by the constant alpha^K (pure XOR network).
module gf5_mul_const
  import bch_pkg::*;
#(
  parameter int unsigned K = 0
) (
  input  gf_t a_i,
  output gf_t p_o
);

  // Each set input bit b contributes alpha^(K+b).
  always_comb begin
    p_o = '0;
    for (int unsigned b = 0; b < M; b++) begin
      if (a_i[b]) p_o = p_o ^ alpha_pow(K + b);
    end
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates sigma(alpha^-i) for i = 0..N-1, one position per clock,
// flags roots per position and reports the root count and an uncorrectable flag.
module bch_chien_search
  import bch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  bch_chien_search_if.slave  bus
);

  chien_state_t state_q, state_d;
  gf_t          term0_q, term0_d;
  gf_t          term1_q, term1_d;
  gf_t          term2_q, term2_d;
  gf_t          term3_q, term3_d;
  logic [3:0]   l_q, l_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [3:0]   root_q, root_d;
  logic         busy_q, busy_d;
  logic         pos_valid_q, pos_valid_d;
  logic [4:0]   err_pos_q, err_pos_d;
  logic         err_flag_q, err_flag_d;
  logic         done_q, done_d;
  logic [3:0]   num_err_q, num_err_d;
  logic         fail_q, fail_d;

  gf_t          term1_nx, term2_nx, term3_nx;
  gf_t          sum;

  // term_j steps by alpha^-j = alpha^(N-j) per position; term0 stays constant.
  gf5_mul_const #(.K(N - 1)) u_mul1 (.a_i(term1_q), .p_o(term1_nx));
  gf5_mul_const #(.K(N - 2)) u_mul2 (.a_i(term2_q), .p_o(term2_nx));
  gf5_mul_const #(.K(N - 3)) u_mul3 (.a_i(term3_q), .p_o(term3_nx));

  assign sum = term0_q ^ term1_q ^ term2_q ^ term3_q;

  // Next-state and registered-output logic for IDLE -> SEARCH -> FIN.
  always_comb begin
    state_d     = state_q;
    term0_d     = term0_q;
    term1_d     = term1_q;
    term2_d     = term2_q;
    term3_d     = term3_q;
    l_d         = l_q;
    cnt_d       = cnt_q;
    root_d      = root_q;
    err_pos_d   = err_pos_q;
    num_err_d   = num_err_q;
    fail_d      = fail_q;
    pos_valid_d = 1'b0;
    err_flag_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SEARCH;
          term0_d   = bus.sigma0;
          term1_d   = bus.sigma1;
          term2_d   = bus.sigma2;
          term3_d   = bus.sigma3;
          l_d       = bus.L;
          cnt_d     = '0;
          root_d    = '0;
          num_err_d = '0;
          fail_d    = 1'b0;
        end
      end
      SEARCH: begin
        pos_valid_d = 1'b1;
        err_pos_d   = cnt_q;
        err_flag_d  = (sum == '0);
        term1_d     = term1_nx;
        term2_d     = term2_nx;
        term3_d     = term3_nx;
        if ((sum == '0) && (root_q != 4'hF)) root_d = root_q + 4'd1;
        if (cnt_q == 5'(N - 1)) state_d = FIN;
        else                    cnt_d   = cnt_q + 5'd1;
      end
      FIN: begin
        done_d    = 1'b1;
        num_err_d = root_q;
        fail_d    = (root_q != l_q) || (l_q > 4'(T));
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy covers the done cycle too, which is already back in IDLE.
    busy_d = (state_d != IDLE) || (state_q == FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      term0_q     <= '0;
      term1_q     <= '0;
      term2_q     <= '0;
      term3_q     <= '0;
      l_q         <= '0;
      cnt_q       <= '0;
      root_q      <= '0;
      busy_q      <= 1'b0;
      pos_valid_q <= 1'b0;
      err_pos_q   <= '0;
      err_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      num_err_q   <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      term0_q     <= term0_d;
      term1_q     <= term1_d;
      term2_q     <= term2_d;
      term3_q     <= term3_d;
      l_q         <= l_d;
      cnt_q       <= cnt_d;
      root_q      <= root_d;
      busy_q      <= busy_d;
      pos_valid_q <= pos_valid_d;
      err_pos_q   <= err_pos_d;
      err_flag_q  <= err_flag_d;
      done_q      <= done_d;
      num_err_q   <= num_err_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.err_pos   = err_pos_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.done      = done_q;
  assign bus.num_err   = num_err_q;
  assign bus.fail      = fail_q;

endmodule

// File: tb/tb_bch_chien_search.sv
// Scoreboard bench for bch_chien_search: stimulus queues expected position/summary records,
// a negedge monitor pops and compares them whenever pos_valid or done is seen.
module tb_bch_chien_search;
  import bch_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bch_chien_search_if bus ();

  bch_chien_search dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0] pos;
    logic       flag;
  } pos_exp_t;

  typedef struct packed {
    logic [3:0] num;
    logic       fail;
  } sum_exp_t;

  pos_exp_t pos_q[$];
  sum_exp_t sum_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented position and every done summary against the queues.
  always @(negedge clk) begin
    pos_exp_t pe;
    sum_exp_t se;
    if (bus.pos_valid === 1'b1) begin
      if (pos_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pos_valid: got err_pos %0d expected none at %0t", bus.err_pos, $time);
      end else begin
        pe = pos_q.pop_front();
        check("err_pos", 32'(bus.err_pos), 32'(pe.pos));
        check("err_flag", 32'(bus.err_flag), 32'(pe.flag));
      end
    end
    if (bus.done === 1'b1) begin
      if (sum_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none at %0t", $time);
      end else begin
        se = sum_q.pop_front();
        check("num_err", 32'(bus.num_err), 32'(se.num));
        check("fail", 32'(bus.fail), 32'(se.fail));
      end
    end
  end

  task automatic push_expect(input logic [30:0] mask, input logic [3:0] num, input logic fl);
    for (int i = 0; i < 31; i++) pos_q.push_back('{pos: 5'(i), flag: mask[i]});
    sum_q.push_back('{num: num, fail: fl});
  endtask

  task automatic pulse_start(input gf_t s0, input gf_t s1, input gf_t s2, input gf_t s3,
                             input logic [3:0] l);
    @(posedge clk);
    #1;
    bus.sigma0 = s0;
    bus.sigma1 = s1;
    bus.sigma2 = s2;
    bus.sigma3 = s3;
    bus.L      = l;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 100 && (pos_q.size() != 0 || sum_q.size() != 0); i++) @(negedge clk);
    checks++;
    if (pos_q.size() != 0 || sum_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending records expected 0", name, pos_q.size() + sum_q.size());
      pos_q.delete();
      sum_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_pos_valid"}, 32'(bus.pos_valid), 32'd0);
    check({tag, "_err_flag"},  32'(bus.err_flag),  32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
    check({tag, "_fail"},      32'(bus.fail),      32'd0);
    check({tag, "_err_pos"},   32'(bus.err_pos),   32'd0);
    check({tag, "_num_err"},   32'(bus.num_err),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.sigma0 = '0;
    bus.sigma1 = '0;
    bus.sigma2 = '0;
    bus.sigma3 = '0;
    bus.L      = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Case 1: sigma = 1, L = 0 -> no roots, no fail.
    push_expect(31'd0, 4'd0, 1'b0);
    pulse_start(5'd1, 5'd0, 5'd0, 5'd0, 4'd0);
    wait_drain("case1");

    // Case 2: single error at position 5 (sigma1 = alpha^5).
    push_expect(31'(1) << 5, 4'd1, 1'b0);
    pulse_start(5'd1, 5'b00101, 5'd0, 5'd0, 4'd1);
    wait_drain("case2");

    // Case 3: errors at 3 and 10 (sigma1 = alpha^3 + alpha^10, sigma2 = alpha^13).
    push_expect((31'(1) << 3) | (31'(1) << 10), 4'd2, 1'b0);
    pulse_start(5'd1, 5'b11001, 5'b11100, 5'd0, 4'd2);
    wait_drain("case3");

    // Case 4: sigma = 1 + alpha*x^2 has one root (x = alpha^15, position 16) but L = 2.
    push_expect(31'(1) << 16, 4'd1, 1'b1);
    pulse_start(5'd1, 5'd0, 5'b00010, 5'd0, 4'd2);
    wait_drain("case4");
    repeat (4) @(negedge clk);
    check("hold_num_err", 32'(bus.num_err), 32'd1);
    check("hold_fail",    32'(bus.fail),    32'd1);
    check("hold_busy",    32'(bus.busy),    32'd0);

    // Case 5: cycle-accurate timing; a second start mid-search must be ignored.
    push_expect(31'(1) << 5, 4'd1, 1'b0);
    pulse_start(5'd1, 5'b00101, 5'd0, 5'd0, 4'd1);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      check($sformatf("t5_busy_k%0d", k),      32'(bus.busy),      32'((k >= 1) && (k <= 33)));
      check($sformatf("t5_pos_valid_k%0d", k), 32'(bus.pos_valid), 32'((k >= 2) && (k <= 32)));
      check($sformatf("t5_done_k%0d", k),      32'(bus.done),      32'(k == 33));
      if (k == 5) begin
        bus.sigma0 = 5'd1;
        bus.sigma1 = 5'b11001;
        bus.sigma2 = 5'b11100;
        bus.sigma3 = 5'd0;
        bus.L      = 4'd2;
        bus.start  = 1'b1;
      end
      if (k == 6) bus.start = 1'b0;
    end
    wait_drain("case5");

    // Case 6: reset while err_pos 12 is presented aborts the search with no done.
    for (int i = 0; i <= 12; i++)
      pos_q.push_back('{pos: 5'(i), flag: (i == 3 || i == 10)});
    pulse_start(5'd1, 5'b11001, 5'b11100, 5'd0, 4'd2);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (bus.pos_valid === 1'b1 && bus.err_pos == 5'd12) found = 1'b1;
    end
    check("abort_reached_pos12", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_pending", 32'(pos_q.size() + sum_q.size()), 32'd0);
    pos_q.delete();
    sum_q.delete();

    push_expect((31'(1) << 3) | (31'(1) << 10), 4'd2, 1'b0);
    pulse_start(5'd1, 5'b11001, 5'b11100, 5'd0, 4'd2);
    wait_drain("case6_rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
